// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
//
// Round-robin arbiter that shares one AND/OR logic unit
// (out1 = in1 & in2, out2 = in3 | in4) among NREQ requesters and registers
// each result, tagged with the winner's index, into a single response slot.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous, active-high
//   req_valid  : [NREQ]   requester i offers a bundle
//   req_ops    : [4*NREQ] requester i operands at [4i+3:4i] = {in4,in3,in2,in1}
//   req_ready  : [NREQ]   one-hot grant (or zero) for this cycle
//   resp_valid : response slot holds a result
//   resp_ready : downstream consumes the slot when high with resp_valid
//   resp_id    : [IDW]    index of the requester that produced the result
//   resp_out1  : registered in1 & in2
//   resp_out2  : registered in3 | in4
//   grant_cnt  : [16]     grant counter, present only with
//                         `define LOGIC_UNIT_ARB_STATS_EN
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requesters keep valid and their operands stable until ready;
// ready never depends on the operands.
// ---------------------------------------------------------------------------

module logic_unit (
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    output logic out1,
    output logic out2
);
    assign out1 = in1 & in2;
    assign out2 = in3 | in4;
endmodule

module logic_unit_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_ops,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_out1,
`ifdef LOGIC_UNIT_ARB_STATS_EN
    output logic [15:0]       grant_cnt,
`endif
    output logic              resp_out2
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic           state;
    logic [IDW-1:0] ptr;
    logic           avail;
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [3:0]     unit_ops;
    logic           unit_out1;
    logic           unit_out2;
    int             scan_idx;

    logic [3:0] ops_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_ops
        assign ops_arr[g] = req_ops[4*g +: 4];
    end

    assign resp_valid = (state == ST_FULL);
    // A full slot being drained this cycle can accept a new result on the
    // same edge, which is what keeps back-to-back throughput at one/cycle.
    assign avail = (state == ST_EMPTY) | (resp_valid & resp_ready);

    // Scan upward from ptr with wrap; the first valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        if (!reset && avail) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = int'(ptr) + k;
                if (scan_idx >= NREQ) begin
                    scan_idx = scan_idx - NREQ;
                end
                if (!grant_any && req_valid[IDW'(scan_idx)]) begin
                    grant_any = 1'b1;
                    grant_idx = IDW'(scan_idx);
                end
            end
        end
    end

    assign req_ready = grant_any ? (NREQ'(1) << grant_idx) : '0;

    // Unit inputs are zeroed when nobody is granted.
    assign unit_ops = grant_any ? ops_arr[grant_idx] : 4'b0000;

    logic_unit u_logic_unit (
        .in1  (unit_ops[0]),
        .in2  (unit_ops[1]),
        .in3  (unit_ops[2]),
        .in4  (unit_ops[3]),
        .out1 (unit_out1),
        .out2 (unit_out2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_EMPTY;
            ptr       <= '0;
            resp_id   <= '0;
            resp_out1 <= 1'b0;
            resp_out2 <= 1'b0;
        end else if (grant_any) begin
            state     <= ST_FULL;
            resp_id   <= grant_idx;
            resp_out1 <= unit_out1;
            resp_out2 <= unit_out2;
            ptr       <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
        end else if (resp_valid && resp_ready) begin
            state <= ST_EMPTY;
        end
    end

`ifdef LOGIC_UNIT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= 16'h0000;
        end else if (grant_any) begin
            grant_cnt <= grant_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_arbiter
//
// Directed and randomized scenarios for logic_unit_arbiter (NREQ=4).
// Expected results {id,out1,out2} are queued when a grant is expected and
// popped by a monitor whenever the DUT's response is consumed.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------

module tb_logic_unit_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = IDW + 2;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_ops;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic              resp_out1;
    logic              resp_out2;
`ifdef LOGIC_UNIT_ARB_STATS_EN
    logic [15:0]       grant_cnt;
`endif

    logic [3:0] ops [NREQ];
    assign req_ops = {ops[3], ops[2], ops[1], ops[0]};

    logic [W-1:0] exp_q[$];
    int checks;
    int fails;

    logic_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ops    (req_ops),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_out1  (resp_out1),
`ifdef LOGIC_UNIT_ARB_STATS_EN
        .grant_cnt  (grant_cnt),
`endif
        .resp_out2  (resp_out2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference helpers ----------------
    function automatic logic [W-1:0] exp_of(input int id, input logic [3:0] o);
        logic [IDW-1:0] id_v;
        id_v = IDW'(id);
        return {id_v, o[0] & o[1], o[2] | o[3]};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            logic [W-1:0] got;
            logic [W-1:0] exp;
            got = {resp_id, resp_out1, resp_out2};
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_unexpected: got {id,o1,o2}=%b, required none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL scoreboard_result: got {id,o1,o2}=%b, required %b", got, exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) ops[i] = 4'b0000;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        drive_idle();
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_req_ready: got %b, required 0000", req_ready);
        end
        checks++;
        if ({resp_valid, resp_id, resp_out1, resp_out2} !== 5'b0) begin
            fails++;
            $display("FAIL reset_resp: got v=%b id=%0d o1=%b o2=%b, required all 0",
                     resp_valid, resp_id, resp_out1, resp_out2);
        end
`ifdef LOGIC_UNIT_ARB_STATS_EN
        checks++;
        if (grant_cnt !== 16'h0000) begin
            fails++; $display("FAIL reset_grant_cnt: got %0d, required 0", grant_cnt);
        end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        drive_idle();
        exp_q.delete();
    endtask

    task automatic test_single();
        ops[0] = 4'b0011; req_valid = 4'b0001; resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("FAIL single_grant: got %b, required 0001", req_ready);
        end
        exp_q.push_back(exp_of(0, 4'b0011));
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_out1 !== 1'b1 || resp_out2 !== 1'b0) begin
            fails++;
            $display("FAIL single_resp: got v=%b id=%0d o1=%b o2=%b, required 1 0 1 0",
                     resp_valid, resp_id, resp_out1, resp_out2);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < NREQ; i++) ops[i] = 4'($urandom_range(0, 15));
        req_valid = 4'b1111; resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % NREQ;
            @(negedge clk);
            checks++;
            if (req_ready !== 4'(1 << g)) begin
                fails++; $display("FAIL rr_grant_%0d: got %b, required %b", k, req_ready, 4'(1 << g));
            end
            if (k > 0) begin
                checks++;
                if (resp_valid !== 1'b1) begin
                    fails++; $display("FAIL rr_no_gap_%0d: got resp_valid=%b, required 1", k, resp_valid);
                end
            end
            exp_q.push_back(exp_of(g, ops[g]));
            next_cycle();
            ops[g] = 4'($urandom_range(0, 15));
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_stall();
        apply_reset();
        ops[2] = 4'b1100; req_valid = 4'b0100; resp_ready = 1'b0;
        @(negedge clk);
        exp_q.push_back(exp_of(2, 4'b1100));
        next_cycle();
        req_valid = 4'b0001;
        ops[0] = 4'($urandom_range(0, 15));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000) begin
                fails++; $display("FAIL stall_ready_%0d: got %b, required 0000", k, req_ready);
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_out1 !== 1'b0 || resp_out2 !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold_%0d: got v=%b id=%0d o1=%b o2=%b, required 1 2 0 1",
                         k, resp_valid, resp_id, resp_out1, resp_out2);
            end
            next_cycle();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("FAIL stall_release_grant: got %b, required 0001", req_ready);
        end
        exp_q.push_back(exp_of(0, ops[0]));
        next_cycle();
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ops[1] = 4'($urandom_range(0, 15));
        ops[3] = 4'($urandom_range(0, 15));
        req_valid = 4'b1010; resp_ready = 1'b0;
        next_cycle();                        // grant to 1, slot now FULL
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL midreset_ready: got %b, required 0000", req_ready);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_id !== 2'd0) begin
            fails++; $display("FAIL midreset_resp: got v=%b id=%0d, required 0 0", resp_valid, resp_id);
        end
        exp_q.delete();
        next_cycle();
        reset = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("FAIL midreset_first_grant: got %b, required 0010", req_ready);
        end
        exp_q.push_back(exp_of(1, ops[1]));
        next_cycle();
        req_valid = 4'b1000;
        @(negedge clk);
        exp_q.push_back(exp_of(3, ops[3]));
        next_cycle();
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_wrap();
        int exp_g[3] = '{3, 0, 3};
        apply_reset();
        ops[2] = 4'($urandom_range(0, 15));
        req_valid = 4'b0100; resp_ready = 1'b1;   // moves ptr to 3
        @(negedge clk);
        exp_q.push_back(exp_of(2, ops[2]));
        next_cycle();
        ops[3] = 4'($urandom_range(0, 15));
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'(1 << exp_g[k])) begin
                fails++; $display("FAIL wrap_grant_%0d: got %b, required %b", k, req_ready, 4'(1 << exp_g[k]));
            end
            exp_q.push_back(exp_of(exp_g[k], ops[exp_g[k]]));
            next_cycle();
            ops[exp_g[k]] = 4'($urandom_range(0, 15));
            req_valid = 4'b1001;
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] pending;
        logic [NREQ-1:0] fresh;
        logic [NREQ-1:0] exp_rdy;
        int m_ptr;
        logic m_full;
        int g;
        apply_reset();
        pending = '0; m_ptr = 0; m_full = 1'b0;
        for (int c = 0; c < 60; c++) begin
            fresh = 4'($urandom_range(0, 15)) & ~pending;
            for (int i = 0; i < NREQ; i++) if (fresh[i]) ops[i] = 4'($urandom_range(0, 15));
            pending    = pending | fresh;
            req_valid  = pending;
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = (!m_full || resp_ready) ? rr_pick(pending, m_ptr) : -1;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            checks++;
            if (req_ready !== exp_rdy || resp_valid !== m_full) begin
                fails++;
                $display("FAIL b2b_cycle_%0d: got ready=%b v=%b, required ready=%b v=%b",
                         c, req_ready, resp_valid, exp_rdy, m_full);
            end
            if (g >= 0) begin
                exp_q.push_back(exp_of(g, ops[g]));
                pending[g] = 1'b0;
                m_ptr  = (g + 1) % NREQ;
                m_full = 1'b1;
            end else if (resp_ready) begin
                m_full = 1'b0;
            end
            next_cycle();
        end
        req_valid = '0; resp_ready = 1'b1;
        repeat (2) next_cycle();
    endtask

`ifdef LOGIC_UNIT_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        ops[0] = 4'b0101;
        req_valid = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            resp_ready = !(i == 2 || i == 5);
            @(negedge clk);
            if (i == 2) begin
                checks++;
                if (grant_cnt !== 16'd2) begin
                    fails++; $display("FAIL stats_hold: got %0d, required 2", grant_cnt);
                end
            end
            if (resp_ready) exp_q.push_back(exp_of(0, 4'b0101));
            next_cycle();
        end
        req_valid = '0; resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_cnt !== 16'd5) begin
            fails++; $display("FAIL stats_count5: got %0d, required 5", grant_cnt);
        end
        next_cycle();

        apply_reset();
        req_valid = 4'b1111; resp_ready = 1'b1;
        for (int k = 0; k < 65536; k++) begin
            @(negedge clk);
            if (k == 65535) begin
                checks++;
                if (grant_cnt !== 16'hFFFF) begin
                    fails++; $display("FAIL stats_max: got %h, required ffff", grant_cnt);
                end
            end
            exp_q.push_back(exp_of(k % NREQ, 4'b0000));
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (grant_cnt !== 16'h0000) begin
            fails++; $display("FAIL stats_wrap: got %h, required 0000", grant_cnt);
        end
        next_cycle();
    endtask
`endif

    // ---------------- sequence and final report ----------------
    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        drive_idle();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
`ifdef LOGIC_UNIT_ARB_STATS_EN
        test_stats();
`endif
        next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin arbiter and scheduler that shares a single instance of the two-output AND/OR logic unit (out1 = in1 & in2, out2 = in3 | in4) among NREQ requesters. Each requester offers a 4-bit operand bundle with a valid/ready handshake. The arbiter grants at most one requester per cycle, drives the shared unit, and registers the result with the winner's ID into a single response slot. The block sits between requester-side control logic and the shared logic unit, and is the only driver of that unit.

## Interface
Parameters:
- NREQ, default 4: number of requesters, 2..8.
- IDW, default 2: response ID width, equal to clog2(NREQ).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset; synchronous, active-high.
- req_valid  input  NREQ  bit i set means requester i offers an operand bundle.
- req_ops  input  4*NREQ  requester i operands at bits [4i+3:4i], ordered {in4,in3,in2,in1}, in1 at the LSB.
- req_ready  output  NREQ  one-hot or zero; bit i set means requester i's bundle is accepted this cycle.
- resp_valid  output  1  response slot holds a result.
- resp_ready  input  1  downstream consumes the response when high together with resp_valid.
- resp_id  output  IDW  index of the requester that produced the result.
- resp_out1  output  1  registered in1 & in2.
- resp_out2  output  1  registered in3 | in4.

## Operation
- The shared logic unit is instantiated once. Its inputs are muxed from the granted requester's req_ops; when no requester is granted, its inputs are driven to 0.
- FSM states:
  - EMPTY: slot free.
  - FULL: slot holds an unconsumed result.
- Slot availability: avail = (state==EMPTY) | (resp_valid & resp_ready).
- Grant: when avail is high and any req_valid bit is set, grant the first set bit found scanning upward from ptr, wrapping NREQ-1 to 0. req_ready has exactly that bit set. Otherwise req_ready = 0.
- On a grant:
  - resp_out1/resp_out2 load the unit outputs.
  - resp_id loads the grant index.
  - state moves to FULL.
  - ptr loads (grant+1) mod NREQ.
- On consume with no grant: state moves to EMPTY. resp_id, resp_out1 and resp_out2 hold their last values.
- Simultaneous consume and grant: the new result replaces the old one in the same edge and state stays FULL. No bubble.
- FULL without resp_ready: all response outputs hold stable. req_ready = 0.
- ptr changes only on a grant.
- req_ready is combinational from req_valid, state, resp_ready and ptr. No combinational path exists from req_ops to any output.
- Requesters hold req_valid and req_ops until they are granted. The arbiter does not check this.

## Timing
- Reset values:
  - state = EMPTY, ptr = 0.
  - resp_valid = 0, resp_id = 0, resp_out1 = 0, resp_out2 = 0.
  - req_ready = 0 while reset is high.
- Reset mid-operation discards any pending result and restarts the round-robin at requester 0.
- Latency: a grant in cycle t gives resp_valid = 1 with the result in cycle t+1.
- Throughput: one result per cycle while resp_ready stays high.
- Fairness: a continuously valid requester is granted within NREQ grants.

## Configuration
- LOGIC_UNIT_ARB_STATS_EN: adds output port grant_cnt, 16 bits.
  - Reset value 0.
  - Increments by 1 on every grant; wraps from 16'hFFFF to 0.
  - Holds during stall cycles.
- Without the macro, the port and counter do not exist. All other behaviour is identical in both builds.

## Test plan
- Reset, then request 0 alone with ops 4'b0011, resp_ready=1 -> req_ready=4'b0001 in cycle 1; cycle 2 gives resp_valid=1, resp_id=0, out1=1, out2=0.
- All four requesters valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0,1 over consecutive cycles with no gaps.
- Requester 2 with ops 4'b1100 and resp_ready=0 for 3 cycles -> resp_valid=1, resp_id=2, out1=0, out2=1 held stable; req_ready=0 throughout; the next grant occurs in the cycle resp_ready rises.
- Reset asserted while FULL with requesters 1 and 3 valid -> next cycle resp_valid=0, ptr=0; first grant after release goes to requester 1.
- Only requester 3 valid after ptr=3, then requesters 0 and 3 valid -> grants 3, then 0 (wrap), then 3.
- With LOGIC_UNIT_ARB_STATS_EN, 5 grants interleaved with 2 stall cycles -> grant_cnt=5; 65536 grants -> grant_cnt wraps to 0.
